// File: rtl/tt_input_debounce_if.sv
// Raw/debounced signal bundle for the NOR-stage input conditioner.
// master drives raw inputs and clear; slave produces the clean levels.
interface tt_input_debounce_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0]   raw_in;
  logic               evt_clr;
  logic [WIDTH-1:0]   db_out;
  logic [WIDTH-1:0]   rise_p;
  logic [WIDTH-1:0]   fall_p;
  logic [4*WIDTH-1:0] evt_cnt;

  modport master (
    output raw_in, evt_clr,
    input  db_out, rise_p, fall_p, evt_cnt
  );

  modport slave (
    input  raw_in, evt_clr,
    output db_out, rise_p, fall_p, evt_cnt
  );
endinterface

// File: rtl/tt_input_debounce.sv
// Per-channel 2-flop synchronizer + stability-count debouncer with edge pulses.
// Optional per-channel rise-event counters when EVT_CNT_EN is defined.
module tt_input_debounce #(
  parameter int WIDTH     = 2,
  parameter int DB_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  tt_input_debounce_if.slave bus
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.raw_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt;

    // A change is accepted only after DB_CYCLES unbroken mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        db[i]   <= 1'b0;
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
      end else begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (s2[i] == db[i]) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt     <= '0;
          db[i]   <= s2[i];
          rise[i] <= s2[i];
          fall[i] <= ~s2[i];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

`ifdef EVT_CNT_EN
  logic [4*WIDTH-1:0] evt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_evt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        evt[4*i +: 4] <= 4'd0;
      end else if (bus.evt_clr) begin
        evt[4*i +: 4] <= 4'd0;
      end else if (rise[i]) begin
        evt[4*i +: 4] <= evt[4*i +: 4] + 4'd1;
      end
    end
  end

  assign bus.evt_cnt = evt;
`else
  logic unused_evt_clr;
  assign unused_evt_clr = bus.evt_clr;
  assign bus.evt_cnt    = '0;
`endif

  assign bus.db_out = db;
  assign bus.rise_p = rise;
  assign bus.fall_p = fall;
endmodule

// File: tb/tb_tt_input_debounce.sv
// Bench for tt_input_debounce: directed scenarios plus random stimulus
// compared every cycle against a sliding-window behavioural model.
module tb_tt_input_debounce;
  localparam int W = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  tt_input_debounce_if #(.WIDTH(W)) bus ();

  tt_input_debounce #(.WIDTH(W), .DB_CYCLES(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: a channel's level flips once the last D synchronized samples
  // all disagree with it; synchronized value = raw delayed two edges.
  logic [W-1:0]   m_p1, m_p2, m_db, m_rise, m_fall;
  logic [4*W-1:0] m_evt;
  logic [W-1:0]   m_hist[$];

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_db = '0;
    m_rise = '0; m_fall = '0; m_evt = '0;
    m_hist.delete();
    repeat (D) m_hist.push_back('0);
  endtask

  task automatic model_step();
`ifdef EVT_CNT_EN
    for (int i = 0; i < W; i++) begin
      if (bus.evt_clr) m_evt[4*i +: 4] = 4'd0;
      else if (m_rise[i]) m_evt[4*i +: 4] = m_evt[4*i +: 4] + 4'd1;
    end
`endif
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      bit all_diff;
      all_diff = 1'b1;
      foreach (m_hist[j]) if (m_hist[j][i] == m_db[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_db[i]   = ~m_db[i];
        m_rise[i] = m_db[i];
        m_fall[i] = ~m_db[i];
      end
    end
    m_p2 = m_p1;
    m_p1 = bus.raw_in;
    m_hist.push_back(m_p2);
    void'(m_hist.pop_front());
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("model_cmp",
          {bus.db_out, bus.rise_p, bus.fall_p, bus.evt_cnt},
          {m_db, m_rise, m_fall, m_evt});
  end

  // Counts edges until the masked level matches; expects exactly exp edges.
  task automatic wait_lvl(input string nm, input logic [W-1:0] mask,
                          input logic [W-1:0] val, input int exp);
    int n;
    n = 0;
    while (n < 30) begin
      @(posedge clk); #2;
      n++;
      if ((bus.db_out & mask) == val) break;
    end
    check(nm, n, exp);
  endtask

  task automatic settle(input logic [W-1:0] v);
    @(negedge clk) bus.raw_in = v;
    repeat (10) @(posedge clk);
  endtask

  task automatic press0();
    @(negedge clk) bus.raw_in[0] = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk) bus.raw_in[0] = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    int nrise;
    int first;
    logic [3:0] exp3, exp15;
    bus.raw_in  = 2'b11;
    bus.evt_clr = 1'b0;

    // Reset with inputs high
    repeat (3) @(posedge clk);
    #2;
    check("rst_db", bus.db_out, 2'b00);
    check("rst_rise", bus.rise_p, 2'b00);
    check("rst_evt", bus.evt_cnt, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    wait_lvl("rst_release_lat", 2'b11, 2'b11, 6);

    // Clean press on ch0
    settle(2'b00);
    @(negedge clk) bus.raw_in[0] = 1'b1;
    wait_lvl("press_lat", 2'b01, 2'b01, 6);
    check("press_rise", bus.rise_p, 2'b01);
    @(posedge clk); #2;
    check("press_rise_end", bus.rise_p, 2'b00);
    check("press_db1", bus.db_out[1], 1'b0);

    // Glitch on ch1: 3 cycles high
    @(negedge clk) bus.raw_in[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) bus.raw_in[1] = 1'b0;
    nrise = 0;
    repeat (12) begin
      @(posedge clk); #2;
      if (bus.rise_p[1]) nrise++;
    end
    check("glitch_rise", nrise, 0);
    check("glitch_db", bus.db_out[1], 1'b0);

    // Bounce on ch0
    settle(2'b00);
    foreach (exp3[k]) begin end
    @(negedge clk) bus.raw_in[0] = 1'b1;
    @(negedge clk) bus.raw_in[0] = 1'b0;
    @(negedge clk) bus.raw_in[0] = 1'b1;
    @(negedge clk) bus.raw_in[0] = 1'b0;
    @(negedge clk) bus.raw_in[0] = 1'b1;
    nrise = 0;
    first = 0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #2;
      if (bus.rise_p[0]) begin
        nrise++;
        if (first == 0) first = e;
      end
    end
    check("bounce_count", nrise, 1);
    check("bounce_lat", first, 6);

    // Reset in the middle of a count
    settle(2'b10);
    check("pre_mid_db", bus.db_out, 2'b10);
    @(negedge clk) bus.raw_in[0] = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_db", bus.db_out, 2'b00);
    check("mid_rst_pulse", {bus.rise_p, bus.fall_p}, 4'h0);
    check("mid_rst_evt", bus.evt_cnt, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_lvl("mid_rst_lat", 2'b11, 2'b11, 6);

    // Event counters
`ifdef EVT_CNT_EN
    exp3 = 4'd3;
    exp15 = 4'd15;
`else
    exp3 = 4'd0;
    exp15 = 4'd0;
`endif
    settle(2'b00);
    @(negedge clk) bus.evt_clr = 1'b1;
    @(negedge clk) bus.evt_clr = 1'b0;
    repeat (3) press0();
    check("evt_three", bus.evt_cnt[3:0], exp3);
    @(negedge clk) bus.raw_in[0] = 1'b1;
    nrise = 0;
    while (nrise < 30) begin
      @(posedge clk); #1;
      nrise++;
      if (bus.rise_p[0]) break;
    end
    check("clr_rise_seen", bus.rise_p[0], 1'b1);
    bus.evt_clr = 1'b1;
    @(posedge clk); #2;
    bus.evt_clr = 1'b0;
    check("clr_priority", bus.evt_cnt[3:0], 4'd0);
    settle(2'b00);
    repeat (15) press0();
    check("evt_fifteen", bus.evt_cnt[3:0], exp15);
    press0();
    check("evt_wrap", bus.evt_cnt[3:0], 4'd0);

    // Random stimulus, model compares every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 7) < 2) bus.raw_in[i] = ~bus.raw_in[i];
      bus.evt_clr = ($urandom_range(0, 31) == 0);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
      end
    end

    repeat (3) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
